tristate_bus_arbiter: RTL and testbench



---
 rtl/tristate_bus_pkg.sv | 17 +
 rtl/rr_pick.sv | 35 +++
 rtl/tristate_bus_arbiter.sv | 117 +++++++++++
 tb/tb_tristate_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tristate_bus_pkg.sv
// Shared types and counter widths for the tri-state bus arbiter.
package tristate_bus_pkg;

    // Arbiter control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    // Turnaround counter holds values 1..7.
    localparam int TURN_CNT_W = 3;

    // Hold counter holds values 1..255 (used only with ARB_HOLD_LIMIT_EN).
    localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set request bit strictly after last_owner,
// wrapping around, so last_owner itself has the lowest priority.
module rr_pick #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last_owner,
    output logic          found,
    output logic [SW-1:0] idx
);

    // Candidate index at each priority slot (slot 0 = highest priority).
    logic [SW-1:0] cand [N];
    logic [N-1:0]  hit;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign cand[gi] = SW'((int'(last_owner) + gi + 1) % N);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Lowest-numbered slot with a pending request wins.
    always_comb begin
        found = |hit;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = cand[i];
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Tri-state bus arbiter: grants one of N requesters a shared line with
// registered one-hot-or-zero driver enables and a turnaround gap between
// owners. Optional feature macro: ARB_HOLD_LIMIT_EN (forces release after
// MAX_HOLD consecutive ownership cycles).
module tristate_bus_arbiter
    import tristate_bus_pkg::*;
#(
    parameter  int N          = 4,
    parameter  int TURNAROUND = 1,
    parameter  int MAX_HOLD   = 8,
    localparam int SW         = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  oe,
    output logic [SW-1:0] sel,
    output logic          busy,
    output logic          owner_valid
);

    // Elaboration-time parameter range guards.
    generate
        if (N < 2 || N > 16) begin : g_bad_n
            $error("tristate_bus_arbiter: N must be 2..16");
        end
        if (TURNAROUND < 1 || TURNAROUND > (1 << TURN_CNT_W) - 1) begin : g_bad_turn
            $error("tristate_bus_arbiter: TURNAROUND must be 1..7");
        end
        if (MAX_HOLD < 2 || MAX_HOLD > (1 << HOLD_CNT_W) - 1) begin : g_bad_hold
            $error("tristate_bus_arbiter: MAX_HOLD must be 2..255");
        end
    endgenerate

    arb_state_t            state_reg;
    logic [SW-1:0]         last_owner_reg;
    logic [TURN_CNT_W-1:0] tcnt_reg;

    logic          found;
    logic [SW-1:0] pick_idx;
    logic          pick_en;
    logic          grant_now;
    logic          release_now;
    logic          hold_expired;

    rr_pick #(.N(N)) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_reg),
        .found      (found),
        .idx        (pick_idx)
    );

    // Arbitration is allowed from IDLE and on the final turnaround cycle, so
    // the bus floats for exactly TURNAROUND cycles between owners.
    assign pick_en     = (state_reg == IDLE) ||
                         ((state_reg == TURN) && (tcnt_reg <= TURN_CNT_W'(1)));
    assign grant_now   = pick_en && found;
    assign release_now = (state_reg == OWN) && (!req[sel] || hold_expired);

`ifdef ARB_HOLD_LIMIT_EN
    logic [HOLD_CNT_W-1:0] hold_reg;

    assign hold_expired = (hold_reg == HOLD_CNT_W'(MAX_HOLD));

    // Counts consecutive cycles with the owner's enable high (1 on first cycle).
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg <= '0;
        end else if (grant_now) begin
            hold_reg <= HOLD_CNT_W'(1);
        end else if (state_reg == OWN) begin
            hold_reg <= hold_reg + 1'b1;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    // Control FSM with registered enables, select and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            oe             <= '0;
            sel            <= '0;
            busy           <= 1'b0;
            owner_valid    <= 1'b0;
            last_owner_reg <= SW'(N - 1);
            tcnt_reg       <= '0;
        end else if (grant_now) begin
            state_reg      <= OWN;
            oe             <= N'(1) << pick_idx;
            sel            <= pick_idx;
            busy           <= 1'b1;
            owner_valid    <= 1'b1;
            last_owner_reg <= pick_idx;
        end else if (release_now) begin
            state_reg   <= TURN;
            oe          <= '0;
            busy        <= 1'b1;
            owner_valid <= 1'b0;
            tcnt_reg    <= TURN_CNT_W'(TURNAROUND);
        end else begin
            case (state_reg)
                TURN: begin
                    if (tcnt_reg > TURN_CNT_W'(1)) begin
                        tcnt_reg <= tcnt_reg - 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Self-checking bench: two arbiters (turnaround 1 and 3) share stimulus and
// are compared every cycle against a behavioural model, plus directed
// literal checks for the key timing scenarios.
module tb_tristate_bus_arbiter;

    localparam int N        = 4;
    localparam int SW       = $clog2(N);
    localparam int MAX_HOLD = 8;
    localparam int TA0      = 1;
    localparam int TA1      = 3;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN  = 1'b1;
`else
    localparam bit HOLD_EN  = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  oe0, oe1;
    logic [SW-1:0] sel0, sel1;
    logic          busy0, busy1, ov0, ov1;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    tristate_bus_arbiter #(.N(N), .TURNAROUND(TA0), .MAX_HOLD(MAX_HOLD)) dut0 (
        .clk(clk), .rst(rst), .req(req),
        .oe(oe0), .sel(sel0), .busy(busy0), .owner_valid(ov0)
    );

    tristate_bus_arbiter #(.N(N), .TURNAROUND(TA1), .MAX_HOLD(MAX_HOLD)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .oe(oe1), .sel(sel1), .busy(busy1), .owner_valid(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester after the previous owner, wrapping.
    function automatic int rr(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Behavioural model: owner (-1 = floating), remaining float cycles,
    // previous owner, ownership length, last shown select.
    int m_owner [2];
    int m_turn  [2];
    int m_last  [2];
    int m_sel   [2];
    int m_hold  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int ta;
            int w;
            ta = (i == 0) ? TA0 : TA1;
            if (rst) begin
                m_owner[i] = -1;
                m_turn[i]  = 0;
                m_last[i]  = N - 1;
                m_sel[i]   = 0;
                m_hold[i]  = 0;
            end else if (m_owner[i] >= 0) begin
                if (!req[m_owner[i]] || (HOLD_EN && m_hold[i] >= MAX_HOLD)) begin
                    m_owner[i] = -1;
                    m_turn[i]  = ta;
                end else begin
                    m_hold[i]++;
                end
            end else if (m_turn[i] > 1) begin
                m_turn[i]--;
            end else begin
                m_turn[i] = 0;
                w = rr(req, m_last[i]);
                if (w >= 0) begin
                    m_owner[i] = w;
                    m_sel[i]   = w;
                    m_last[i]  = w;
                    m_hold[i]  = 1;
                    if (i == 0) $display("grant dut0 owner=%0d t=%0t", w, $time);
                end
            end
        end
    end

    // Every-cycle comparison of both arbiters against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [N-1:0]  g_oe;
                logic [SW-1:0] g_sel;
                logic          g_busy, g_ov;
                logic [N-1:0]  e_oe;
                g_oe   = (i == 0) ? oe0 : oe1;
                g_sel  = (i == 0) ? sel0 : sel1;
                g_busy = (i == 0) ? busy0 : busy1;
                g_ov   = (i == 0) ? ov0 : ov1;
                e_oe   = (m_owner[i] >= 0) ? N'(1) << m_owner[i] : '0;
                chk($sformatf("oe[dut%0d]", i), 32'(g_oe), 32'(e_oe));
                chk($sformatf("sel[dut%0d]", i), 32'(g_sel), 32'(m_sel[i]));
                chk($sformatf("busy[dut%0d]", i), 32'(g_busy),
                    32'((m_owner[i] >= 0) || (m_turn[i] > 0)));
                chk($sformatf("owner_valid[dut%0d]", i), 32'(g_ov), 32'(m_owner[i] >= 0));
                chk($sformatf("onehot[dut%0d]", i), 32'($countones(g_oe) <= 1), 32'(1));
            end
        end
    end

    int grants[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        chk_en = 1'b1;

        // Idle after reset: nothing driven.
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("idle_oe", 32'(oe0), 32'h0);
            chk("idle_busy", 32'(busy0), 32'h0);
            chk("idle_sel", 32'(sel0), 32'h0);
        end

        // Single requester: 1-cycle grant latency, 1-cycle turnaround.
        req = 4'b0010;
        tick();
        chk("grant1_oe", 32'(oe0), 32'h2);
        chk("grant1_sel", 32'(sel0), 32'h1);
        chk("grant1_ov", 32'(ov0), 32'h1);
        tick(); tick(); tick();
        req = 4'b0000;
        tick();
        chk("release_oe", 32'(oe0), 32'h0);
        chk("release_busy", 32'(busy0), 32'h1);
        tick();
        chk("release_idle_busy", 32'(busy0), 32'h0);

        // Reset mid-ownership drops the bus with no turnaround.
        req = 4'b0100;
        tick();
        chk("own2_oe", 32'(oe0), 32'h4);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_oe", 32'(oe0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        rst = 1'b0;
        req = 4'b0101;
        tick();
        chk("post_rst_oe", 32'(oe0), 32'h1);

        // Three-cycle turnaround on dut1 with a waiting requester.
        req = 4'b0000;
        repeat (10) tick();
        req = 4'b0010;
        tick();
        chk("ta3_own_oe", 32'(oe1), 32'h2);
        req = 4'b1010;
        tick();
        chk("ta3_hold_oe", 32'(oe1), 32'h2);
        req = 4'b1000;
        for (int t = 1; t <= 3; t++) begin
            tick();
            chk("ta3_gap_oe", 32'(oe1), 32'h0);
        end
        tick();
        chk("ta3_next_oe", 32'(oe1), 32'h8);
        req = 4'b0000;
        repeat (10) tick();

        // All requesting, each owner briefly drops: rotation 0,1,2,3,0.
        begin
            int own_cnt;
            logic [N-1:0] prev_oe;
            own_cnt = 0;
            prev_oe = '0;
            req = 4'b1111;
            for (int t = 0; t < 60 && grants.size() < 5; t++) begin
                tick();
                if (oe0 != '0 && oe0 != prev_oe) grants.push_back(onehot_idx(oe0));
                own_cnt = (oe0 != '0) ? own_cnt + 1 : 0;
                req = (own_cnt == 2) ? (4'b1111 & ~oe0) : 4'b1111;
                prev_oe = oe0;
            end
            chk("rotation_count", 32'(grants.size()), 32'd5);
            for (int k = 0; k < 5 && k < grants.size(); k++) begin
                chk($sformatf("rotation_%0d", k), 32'(grants[k]), 32'(exp_order[k]));
            end
        end

        // Two continuous requesters: hold limit behaviour.
        req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0011;
        for (int t = 1; t <= 30; t++) begin
            logic [N-1:0] e;
            tick();
            if (HOLD_EN) begin
                e = (((t - 1) % 9) == 8) ? 4'b0000 :
                    ((((t - 1) / 9) % 2) == 0) ? 4'b0001 : 4'b0010;
            end else begin
                e = 4'b0001;
            end
            chk("hold_oe", 32'(oe0), 32'(e));
        end

        // Randomized traffic with occasional resets.
        req = 4'b0000;
        for (int t = 0; t < 3000; t++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
